edge_bit_packer: RTL and testbench
==================================

Name: edge_bit_packer

Overview:
- Sits directly downstream of the edge-detection pipeline output (vsync/hsync/de plus 8-bit edge pixel).
- Binarizes each edge pixel to 1 bit and packs 8 pixels MSB-first into bytes.
- Buffers the bytes in a FIFO and streams them out over a valid/ready interface to the host/plotter link, with start-of-frame and end-of-line markers.

Parameters:
- WIDTH, 8, input pixel width.
- H_RES, 176, active pixels per line that are packed; extra pixels are ignored.
- V_RES, 144, active lines per frame that are packed; extra lines are ignored.
- BIN_TH, 128, binarization threshold; bit = (i_data >= BIN_TH).
- FIFO_DEPTH, 64, byte FIFO entries; power of two, at least 4.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- i_vsync, in, 1, frame-start marker, active high, arrives before the first line.
- i_hsync, in, 1, line sync (unused for packing, kept for interface symmetry).
- i_de, in, 1, pixel valid.
- i_data, in, WIDTH, edge pixel (0 or 255 nominal).
- o_tdata, out, 8, packed byte, MSB = leftmost pixel.
- o_tvalid, out, 1, byte valid.
- i_tready, in, 1, consumer ready.
- o_tuser_sof, out, 1, first byte of frame; qualified by o_tvalid.
- o_tlast_eol, out, 1, last byte of a line; qualified by o_tvalid.
- o_frame_done, out, 1, one-cycle pulse when the last byte of line V_RES-1 is written to the FIFO.
- o_overflow, out, 1, sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: all outputs 0; FIFO empty; column, line, bit and byte counters 0; sof_pending = 0.
- Rising edge of i_vsync:
  - Clears column, line and bit counters and the partial shift register.
  - Sets sof_pending.
  - Does not flush the FIFO; bytes already queued still drain.
- Pixel accept: on i_de = 1 with column < H_RES and line < V_RES, shift in the bit and increment column.
- Byte completion:
  - On the 8th bit, the byte is formed and pushed the next cycle, carrying {sof = sof_pending, eol = (column == H_RES)}.
  - sof_pending clears when the byte is pushed.
- Line end (i_de falling edge):
  - If bits are pending, flush them padded with zeros in the LSBs, with eol = 1.
  - If column > 0, increment line and clear column.
  - Bytes per line = ceil(H_RES/8); 22 at the default.
- A de-gap in mid-line (de low with column < H_RES) counts as line end. Packing is line-by-de-burst.
- Pixel width rule: only the comparison i_data >= BIN_TH is used; no arithmetic on pixel values.
- FIFO:
  - Synchronous, entries are 10 bits {sof, eol, data}.
  - Push is allowed when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and o_overflow is set; it clears only on rst.
- Latency:
  - o_tvalid rises 2 cycles after the 8th pixel's i_de cycle when the FIFO was empty (1 cycle pack register, 1 cycle FIFO write).
  - Output is first-word-fall-through: o_tdata, o_tuser_sof and o_tlast_eol are stable while o_tvalid = 1 and i_tready = 0.
  - A pop occurs on o_tvalid && i_tready.
  - o_tvalid stays high back-to-back while the FIFO is non-empty.
- Full/empty: empty gives o_tvalid = 0. Full plus incoming byte with no pop gives drop and overflow. Pointers wrap modulo FIFO_DEPTH.
- o_frame_done: pulses in the same cycle as the push of the final eol byte of line V_RES-1. Later lines are ignored until the next vsync.
- Reset mid-frame: everything is discarded immediately. The first byte after reset is never marked sof until a vsync is seen.

Optional Feature:
- Macro: EDGE_BIT_PACKER_LINE_CKSUM_EN.
- When defined:
  - After each line's last data byte, one extra byte equal to the XOR of that line's data bytes is pushed.
  - eol moves from the last data byte to the checksum byte.
  - Bytes per line become ceil(H_RES/8)+1; o_frame_done aligns to the checksum byte push.
  - The checksum push follows the same FIFO full/drop rule.
- When undefined: no checksum byte; behaviour exactly as above.

Test Plan:
- Reset, vsync, one line of 176 pixels alternating 255/0 with i_tready = 1 -> 22 bytes of 0xAA; first has sof = 1; 22nd has eol = 1; first o_tvalid 2 cycles after the 8th pixel.
- H_RES = 12, pixels 255×12 -> bytes 0xFF, 0xF0 (zero-padded); eol on 0xF0.
- Full frame V_RES = 144 of all 0 pixels, i_tready = 1 -> 3168 bytes of 0x00; o_frame_done pulses once; o_overflow = 0.
- i_tready = 0 for an entire line with FIFO_DEPTH = 16 and 22 bytes/line -> 16 bytes held, 6 dropped, o_overflow = 1 and stays 1; then i_tready = 1 -> exactly 16 bytes drain in order, o_tdata stable while stalled.
- Mid-line assert rst after 5 bytes -> o_tvalid = 0 immediately; next vsync plus line -> sof on first byte, counts restart from column 0.
- With EDGE_BIT_PACKER_LINE_CKSUM_EN, line of bytes 0x0F, 0xF0, 0xFF -> checksum 0x00 appended with eol; the 0xFF byte has eol = 0.

Source files
------------

// File: rtl/edge_bit_packer.sv
// -----------------------------------------------------------------------------
// edge_bit_packer
//
// Purpose:
//   Takes the edge-detector video stream, reduces each pixel to one bit
//   (i_data >= BIN_TH) and packs eight bits MSB-first into a byte. Bytes are
//   queued in a first-word-fall-through FIFO and streamed out over a
//   valid/ready link. Each byte carries two flags:
//     - start-of-frame: set on the first byte after a vsync.
//     - end-of-line: set on the last byte of a line.
//   Packing follows de bursts. A falling edge of i_de closes the line. Any
//   partial byte is flushed at that point, zero-padded in the LSBs.
//
// Optional build macro:
//   EDGE_BIT_PACKER_LINE_CKSUM_EN
//     When defined, one extra byte is appended after each line's data bytes.
//     It is the XOR of that line's data bytes and it carries the
//     end-of-line flag.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   i_vsync       frame start; a rising edge restarts line/column counting
//   i_hsync       line sync, not used for packing
//   i_de          pixel valid
//   i_data        edge pixel, WIDTH bits
//   o_tdata       packed byte, MSB = leftmost pixel
//   o_tvalid      byte valid (FIFO not empty)
//   i_tready      consumer ready; a pop happens on o_tvalid && i_tready
//   o_tuser_sof   first byte of frame, qualified by o_tvalid
//   o_tlast_eol   last byte of line, qualified by o_tvalid
//   o_frame_done  one-cycle pulse while the final byte of line V_RES-1
//                 is offered to the FIFO
//   o_overflow    sticky: a byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module edge_bit_packer #(
    parameter int WIDTH      = 8,
    parameter int H_RES      = 176,
    parameter int V_RES      = 144,
    parameter int BIN_TH     = 128,
    parameter int FIFO_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_data,
    output logic [7:0]       o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tuser_sof,
    output logic             o_tlast_eol,
    output logic             o_frame_done,
    output logic             o_overflow
);

    localparam int CW   = $clog2(H_RES + 1);
    localparam int LW   = $clog2(V_RES + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [WIDTH-1:0] TH = WIDTH'(BIN_TH);

    // ---------------- input side state ----------------
    logic          vsync_d_reg;
    logic          de_d_reg;
    logic [CW-1:0] col_reg;
    logic [LW-1:0] line_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          sof_pending_reg;

    // Pack register: holds one formed byte for the cycle it is pushed.
    logic          pack_valid_reg;
    logic [7:0]    pack_data_reg;
    logic          pack_sof_reg;
    logic          pack_eol_reg;
    logic          pack_done_reg;

`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
    logic [7:0]    cksum_acc_reg;
    logic [7:0]    cksum_hold_reg;
    logic          cksum_pending_reg;
    logic          cksum_last_reg;
    logic          cksum_close;
`endif

    // ---------------- FIFO state ----------------
    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic            overflow_reg;

    // ---------------- input side decode ----------------
    logic          vsync_rise;
    logic          accept;
    logic          pix_bit;
    logic [7:0]    shift_in;
    logic [CW-1:0] col_inc;
    logic          byte_full;
    logic          line_end;
    logic          flush;
    logic [3:0]    pad_amt;
    logic          form;
    logic [7:0]    form_data;
    logic          form_line_end;
    logic          last_line;
    logic          unused_hsync;

    assign unused_hsync  = i_hsync;
    assign vsync_rise    = i_vsync & ~vsync_d_reg;
    assign pix_bit       = (i_data >= TH);
    assign shift_in      = {shift_reg[6:0], pix_bit};
    assign col_inc       = col_reg + CW'(1);
    assign accept        = i_de && (col_reg < CW'(H_RES)) && (line_reg < LW'(V_RES)) && !vsync_rise;
    assign byte_full     = accept && (bit_cnt_reg == 3'd7);
    assign line_end      = de_d_reg && !i_de && !vsync_rise;
    assign flush         = line_end && (bit_cnt_reg != 3'd0);
    // Left-align the partial byte so padding zeros land in the LSBs.
    assign pad_amt       = 4'd8 - {1'b0, bit_cnt_reg};
    assign form          = byte_full || flush;
    assign form_data     = byte_full ? shift_in : (shift_reg << pad_amt);
    assign form_line_end = flush || (byte_full && (col_inc == CW'(H_RES)));
    assign last_line     = (line_reg == LW'(V_RES - 1));

`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
    // A line also closes when de drops exactly on a byte boundary short of
    // H_RES; nothing is flushed then, but the checksum is still owed.
    assign cksum_close = form_line_end ||
                         (line_end && (bit_cnt_reg == 3'd0) && (col_reg != '0) &&
                          (col_reg != CW'(H_RES)));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d_reg       <= 1'b0;
            de_d_reg          <= 1'b0;
            col_reg           <= '0;
            line_reg          <= '0;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            sof_pending_reg   <= 1'b0;
            pack_valid_reg    <= 1'b0;
            pack_data_reg     <= '0;
            pack_sof_reg      <= 1'b0;
            pack_eol_reg      <= 1'b0;
            pack_done_reg     <= 1'b0;
`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
            cksum_acc_reg     <= '0;
            cksum_hold_reg    <= '0;
            cksum_pending_reg <= 1'b0;
            cksum_last_reg    <= 1'b0;
`endif
        end else begin
            vsync_d_reg    <= i_vsync;
            de_d_reg       <= i_de;
            pack_valid_reg <= 1'b0;
            if (vsync_rise) begin
                // Restart frame counting; bytes already queued keep draining.
                col_reg           <= '0;
                line_reg          <= '0;
                bit_cnt_reg       <= '0;
                shift_reg         <= '0;
                sof_pending_reg   <= 1'b1;
`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
                cksum_acc_reg     <= '0;
                cksum_pending_reg <= 1'b0;
`endif
            end else begin
                if (accept) begin
                    shift_reg   <= byte_full ? 8'h00 : shift_in;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    col_reg     <= col_inc;
                end
                if (line_end) begin
                    shift_reg   <= '0;
                    bit_cnt_reg <= '0;
                    if (col_reg != '0) begin
                        col_reg  <= '0;
                        line_reg <= line_reg + LW'(1);
                    end
                end
                if (form) begin
                    pack_valid_reg  <= 1'b1;
                    pack_data_reg   <= form_data;
                    pack_sof_reg    <= sof_pending_reg;
                    sof_pending_reg <= 1'b0;
`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
                    pack_eol_reg    <= 1'b0;
                    pack_done_reg   <= 1'b0;
`else
                    pack_eol_reg    <= form_line_end;
                    pack_done_reg   <= form_line_end && last_line;
`endif
                end
`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
                // The checksum byte takes the pack register the cycle after
                // the line closes.
                if (cksum_pending_reg) begin
                    cksum_pending_reg <= 1'b0;
                    pack_valid_reg    <= 1'b1;
                    pack_data_reg     <= cksum_hold_reg;
                    pack_sof_reg      <= 1'b0;
                    pack_eol_reg      <= 1'b1;
                    pack_done_reg     <= cksum_last_reg;
                end
                if (cksum_close) begin
                    cksum_pending_reg <= 1'b1;
                    cksum_hold_reg    <= cksum_acc_reg ^ (form ? form_data : 8'h00);
                    cksum_acc_reg     <= '0;
                    cksum_last_reg    <= last_line;
                end else if (form) begin
                    cksum_acc_reg <= cksum_acc_reg ^ form_data;
                end
`endif
            end
        end
    end

    // ---------------- FIFO ----------------
    logic full;
    logic pop;
    logic push;

    assign o_tvalid = (count_reg != '0);
    assign full     = (count_reg == CNTW'(FIFO_DEPTH));
    assign pop      = o_tvalid && i_tready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = pack_valid_reg && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {pack_sof_reg, pack_eol_reg, pack_data_reg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
            if (pack_valid_reg && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head entry falls through; outputs read as zero while empty.
    logic [9:0] head;
    assign head         = mem[rd_ptr_reg];
    assign o_tdata      = o_tvalid ? head[7:0] : 8'h00;
    assign o_tlast_eol  = o_tvalid && head[8];
    assign o_tuser_sof  = o_tvalid && head[9];
    assign o_frame_done = pack_valid_reg && pack_done_reg;
    assign o_overflow   = overflow_reg;

endmodule

// File: tb/tb_edge_bit_packer.sv
// -----------------------------------------------------------------------------
// tb_edge_bit_packer
//
// Two packers share one video stream. DUT A uses the default geometry with a
// 16-entry FIFO. DUT B uses a 12-pixel, 3-line geometry with its own threshold.
// Each de burst is turned into expected bytes by a line-level model and queued
// per DUT. A negedge monitor pops and compares every accepted byte. It also
// checks that the head stays stable while stalled.
// -----------------------------------------------------------------------------
module tb_edge_bit_packer;

    localparam int HA = 176, VA = 144, THA = 128, DA = 16;
    localparam int HB = 12,  VB = 3,   THB = 100, DB = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b0;
    logic       hsync = 1'b0;
    logic       de = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tready_a, tready_b;
    logic [7:0] o_tdata_a, o_tdata_b;
    logic       o_tvalid_a, o_tvalid_b;
    logic       o_sof_a, o_sof_b, o_eol_a, o_eol_b;
    logic       o_done_a, o_done_b, o_ovf_a, o_ovf_b;

    edge_bit_packer #(.WIDTH(8), .H_RES(HA), .V_RES(VA), .BIN_TH(THA), .FIFO_DEPTH(DA)) dut_a (
        .clk(clk), .rst(rst), .i_vsync(vsync), .i_hsync(hsync), .i_de(de), .i_data(data),
        .o_tdata(o_tdata_a), .o_tvalid(o_tvalid_a), .i_tready(tready_a),
        .o_tuser_sof(o_sof_a), .o_tlast_eol(o_eol_a), .o_frame_done(o_done_a),
        .o_overflow(o_ovf_a));

    edge_bit_packer #(.WIDTH(8), .H_RES(HB), .V_RES(VB), .BIN_TH(THB), .FIFO_DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst), .i_vsync(vsync), .i_hsync(hsync), .i_de(de), .i_data(data),
        .o_tdata(o_tdata_b), .o_tvalid(o_tvalid_b), .i_tready(tready_b),
        .o_tuser_sof(o_sof_b), .o_tlast_eol(o_eol_b), .o_frame_done(o_done_b),
        .o_overflow(o_ovf_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    int  m_line[2];
    int  m_sof[2];
    int  done_exp[2];
    int  done_seen[2];
    int  pix[256];
    int  mode_a = 1, mode_b = 1;
    bit  ignore = 1'b0;
    bit  lat_arm = 1'b0;
    int  lat_start = 0;
    bit  stall[2];
    logic [9:0] prev[2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic pick(input int m);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    initial begin
        tready_a = 1'b1;
        tready_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready_a = pick(mode_a);
            tready_b = pick(mode_b);
        end
    end

    // Expected bytes for one de burst of n pixels taken from pix[].
    // Only the first `limit` bytes are queued; the rest are expected to drop.
    task automatic model_burst(input int id, input int n, input int limit);
        int h, v, th, m, nb, b, x, pushed, idx;
        bit eol_last, sof, eol;
        logic [9:0] e;
        h  = (id == 0) ? HA : HB;
        v  = (id == 0) ? VA : VB;
        th = (id == 0) ? THA : THB;
        if (m_line[id] >= v || n == 0) return;
        m  = (n < h) ? n : h;
        nb = (m + 7) / 8;
        x  = 0;
        pushed = 0;
        // A partial last byte is flushed with eol; a full one is eol only at H.
        eol_last = ((m % 8) != 0) || (m == h);
        for (int k = 0; k < nb; k++) begin
            b = 0;
            for (int j = 0; j < 8; j++) begin
                idx = k * 8 + j;
                b = (b << 1) | (((idx < m) && (pix[idx] >= th)) ? 1 : 0);
            end
            sof = (k == 0) ? m_sof[id][0] : 1'b0;
`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
            eol = 1'b0;
            x = x ^ b;
`else
            eol = (k == nb - 1) && eol_last;
`endif
            e = {sof, eol, 8'(b)};
            if (pushed < limit) begin
                if (id == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            pushed++;
        end
`ifdef EDGE_BIT_PACKER_LINE_CKSUM_EN
        e = {1'b0, 1'b1, 8'(x)};
        if (pushed < limit) begin
            if (id == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        pushed++;
        if (m_line[id] == v - 1) done_exp[id]++;
`else
        if (eol_last && m_line[id] == v - 1) done_exp[id]++;
`endif
        $display("line dut=%0d idx=%0d pixels=%0d bytes=%0d queued=%0d", id, m_line[id], m,
                 pushed, (pushed < limit) ? pushed : limit);
        m_sof[id] = 0;
        m_line[id]++;
    endtask

    task automatic drive_burst(input int n, input int lim_a, input bit arm_lat);
        model_burst(0, n, lim_a);
        model_burst(1, n, 1000);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            de = 1'b1;
            data = pix[i][7:0];
            if (arm_lat && i == 7) begin
                lat_start = cyc;
                lat_arm = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        de = 1'b0;
        data = 8'h00;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_vsync();
        @(posedge clk);
        #1;
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_line[i] = 0;
            m_sof[i] = 1;
        end
    endtask

    // mode 0 zeros, 1 alternating 255/0, 2 random 0/255, 3 values near thresholds
    task automatic fill_pix(input int mode, input int n);
        int vals[6];
        vals = '{0, 99, 100, 127, 128, 255};
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       pix[i] = 0;
                1:       pix[i] = (i % 2 == 0) ? 255 : 0;
                2:       pix[i] = ($urandom_range(0, 1) != 0) ? 255 : 0;
                default: pix[i] = vals[$urandom_range(0, 5)];
            endcase
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        check({tag, "_left_a"}, q_a.size(), 0);
        check({tag, "_left_b"}, q_b.size(), 0);
    endtask

    task automatic mon_port(input int id, input logic v, input logic r, input logic [9:0] cur);
        logic [9:0] e;
        if (stall[id] && v) begin
            check((id == 0) ? "hold_a" : "hold_b", cur, prev[id]);
        end
        if (v && r && !ignore) begin
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte dut=%0d: got 0x%0h, required no byte", id, cur);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                check((id == 0) ? "byte_a" : "byte_b", cur, e);
            end
        end
        stall[id] = v && !r;
        prev[id] = cur;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall[0] = 1'b0;
                stall[1] = 1'b0;
            end else begin
                if (lat_arm && o_tvalid_a) begin
                    check("latency_a", cyc - lat_start, 2);
                    lat_arm = 1'b0;
                end
                mon_port(0, o_tvalid_a, tready_a, {o_sof_a, o_eol_a, o_tdata_a});
                mon_port(1, o_tvalid_b, tready_b, {o_sof_b, o_eol_b, o_tdata_b});
                if (o_done_a) done_seen[0]++;
                if (o_done_b) done_seen[1]++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pat;
        for (int i = 0; i < 2; i++) begin
            m_line[i] = 0; m_sof[i] = 0; done_exp[i] = 0; done_seen[i] = 0;
            stall[i] = 1'b0; prev[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_a", o_tvalid_a, 0);
        check("rst_data_a", o_tdata_a, 0);
        check("rst_sof_a", o_sof_a, 0);
        check("rst_eol_a", o_eol_a, 0);
        check("rst_done_a", o_done_a, 0);
        check("rst_ovf_a", o_ovf_a, 0);
        check("rst_valid_b", o_tvalid_b, 0);
        check("rst_ovf_b", o_ovf_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Alternating line: 22 x 0xAA on A, 0xAA/0xA0 on B.
        do_vsync();
        fill_pix(1, HA);
        drive_burst(HA, 1000, 1'b1);

        // Line of 0x0F, 0xF0, 0xFF.
        pat = 24'h0FF0FF;
        for (int i = 0; i < 24; i++) pix[i] = pat[23 - i] ? 255 : 0;
        drive_burst(24, 1000, 1'b0);
        wait_drain("directed");

        // Random bursts with random backpressure; short bursts are mid-line gaps.
        mode_a = 2;
        mode_b = 2;
        for (int f = 0; f < 5; f++) begin
            do_vsync();
            for (int l = 0; l < 5; l++) begin
                int n;
                n = $urandom_range(1, 200);
                fill_pix($urandom_range(2, 3), n);
                drive_burst(n, 1000, 1'b0);
            end
        end
        wait_drain("random");

        // Full frame of zeros plus extra lines that must be ignored.
        mode_a = 1;
        do_vsync();
        fill_pix(0, HA);
        for (int l = 0; l < VA + 6; l++) drive_burst(HA, 1000, 1'b0);
        wait_drain("frame");
        check("frame_done_a", done_seen[0], done_exp[0]);
        check("frame_done_b", done_seen[1], done_exp[1]);
        check("ovf_a_frame", o_ovf_a, 0);

        // Stall A for a whole line: 16 held, 6 dropped.
        mode_a = 0;
        repeat (2) @(posedge clk);
        do_vsync();
        fill_pix(2, HA);
        drive_burst(HA, DA, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("ovf_a_set", o_ovf_a, 1);
        check("ovf_b_clear", o_ovf_b, 0);
        check("held_a_valid", o_tvalid_a, 1);
        mode_a = 2;
        wait_drain("drop");
        @(negedge clk);
        check("ovf_a_sticky", o_ovf_a, 1);
        check("empty_a", o_tvalid_a, 0);

        // Reset in mid-line after about five bytes on A.
        mode_a = 1;
        mode_b = 1;
        do_vsync();
        ignore = 1'b1;
        fill_pix(2, 60);
        for (int i = 0; i < 44; i++) begin
            @(posedge clk);
            #1;
            de = 1'b1;
            data = pix[i][7:0];
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_a", o_tvalid_a, 0);
        check("rst_mid_valid_b", o_tvalid_b, 0);
        check("rst_mid_ovf_a", o_ovf_a, 0);
        de = 1'b0;
        data = 8'h00;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 2; i++) begin
            m_line[i] = 0;
            m_sof[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ignore = 1'b0;
        repeat (2) @(posedge clk);
        // No vsync yet: no sof. Then vsync: sof on the first byte.
        fill_pix(3, HA);
        drive_burst(HA, 1000, 1'b0);
        do_vsync();
        fill_pix(2, HA);
        drive_burst(HA, 1000, 1'b0);
        mode_a = 2;
        mode_b = 2;
        wait_drain("final");
        check("final_done_a", done_seen[0], done_exp[0]);
        check("final_done_b", done_seen[1], done_exp[1]);
        check("final_ovf_a", o_ovf_a, 0);
        check("final_ovf_b", o_ovf_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
